// File: rtl/dds_burst_gen.sv
// Multi-channel DDS burst excitation generator: per-channel register bank, phase
// accumulator, waveform shaper, burst sequencer and sample strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | output parked at midscale, waiting for a trigger
// ST_BURST | accumulator running, counting periods until BURST_N wraps
// ST_GAP   | continuous mode pause of max(GAP,1) clocks before next burst
module dds_burst_gen #(
    parameter int          NCH       = 2,
    parameter int          ACC_W     = 32,
    parameter int          OUT_W     = 12,
    parameter logic [7:0]  BASE_ADDR = 8'h10
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   m_wr,
    input  logic [7:0]             m_addr,
    input  logic [15:0]            m_wrdata,
    input  logic [NCH-1:0]         ext_trig,
    output logic [NCH*OUT_W-1:0]   dds_data,
    output logic [NCH-1:0]         burst_active,
    output logic [NCH-1:0]         burst_done,
    output logic [NCH-1:0]         sample_flag
);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [7:0]     rel_addr;
    logic           addr_hit;
    logic [NCH-1:0] trig_d;

    assign rel_addr = m_addr - BASE_ADDR;
    assign addr_hit = m_wr && (m_addr >= BASE_ADDR) && ({1'b0, rel_addr} < 9'(8 * NCH));

    always_ff @(posedge Clk) begin
        if (!Rst_n) trig_d <= '0;
        else        trig_d <= ext_trig;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             ch_wr;
        logic [2:0]       reg_sel;
        logic             en, cont;
        logic [1:0]       mode;
        logic [15:0]      fw_l, fw_h, pw, burst_n, gap, sdiv;
        logic [ACC_W-1:0] fw, acc;
        logic [ACC_W:0]   acc_sum;
        logic             wrap, trig, last_period, load_acc, done_nx;
        logic [15:0]      period_cnt, gap_cnt, smp_cnt;
        state_t           state, state_nx;
        logic [OUT_W-2:0] tri_t;
        logic [OUT_W-1:0] wave, dds_q;
        logic             done_q, flag_q;

        assign ch_wr   = addr_hit && (rel_addr[7:3] == 5'(c));
        assign reg_sel = rel_addr[2:0];

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                {cont, mode, en} <= 4'h0;
                fw_l    <= 16'h12B0;
                fw_h    <= 16'h0083;
                pw      <= 16'd0;
                burst_n <= 16'd5;
                gap     <= 16'd500;
                sdiv    <= 16'd5;
            end else if (ch_wr) begin
                case (reg_sel)
                    3'd0:    {cont, mode, en} <= m_wrdata[3:0];
                    3'd1:    fw_l    <= m_wrdata;
                    3'd2:    fw_h    <= m_wrdata;
                    3'd3:    pw      <= m_wrdata;
                    3'd4:    burst_n <= m_wrdata;
                    3'd5:    gap     <= m_wrdata;
                    3'd6:    sdiv    <= m_wrdata;
                    default: ;
                endcase
            end
        end

        assign fw          = ACC_W'({fw_h, fw_l});
        assign acc_sum     = {1'b0, acc} + {1'b0, fw};
        assign wrap        = acc_sum[ACC_W];
        assign trig        = (ch_wr && reg_sel == 3'd7) || (ext_trig[c] && !trig_d[c]);
        // >= rather than == so a live BURST_N reduction still terminates the burst
        assign last_period = ({1'b0, period_cnt} + 17'd1) >= {1'b0, burst_n};

        always_comb begin
            state_nx = state;
            load_acc = 1'b0;
            done_nx  = 1'b0;
            if (!en) begin
                state_nx = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (trig && burst_n != 16'd0) begin
                        state_nx = ST_BURST;
                        load_acc = 1'b1;
                    end
                    ST_BURST: if (wrap && last_period) begin
                        done_nx  = 1'b1;
                        state_nx = cont ? ST_GAP : ST_IDLE;
                    end
                    ST_GAP: if (gap_cnt == 16'd0) begin
                        state_nx = ST_BURST;
                        load_acc = 1'b1;
                    end
                    default: state_nx = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge Clk) begin
            if (!Rst_n) state <= ST_IDLE;
            else        state <= state_nx;
        end

        always_comb begin
            tri_t = acc[ACC_W-2 -: OUT_W-1];
            case (mode)
                2'd1:    wave = acc[ACC_W-1 -: OUT_W];
                2'd2:    wave = {acc[ACC_W-1] ? ~tri_t : tri_t, 1'b0};
                default: wave = acc[ACC_W-1] ? '1 : '0;
            endcase
        end

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                acc        <= '0;
                period_cnt <= 16'd0;
                gap_cnt    <= 16'd0;
                done_q     <= 1'b0;
                dds_q      <= MIDSCALE;
            end else begin
                done_q <= done_nx;
                // midscale as soon as the burst is leaving, not one sample later
                dds_q  <= (state == ST_BURST && state_nx == ST_BURST) ? wave : MIDSCALE;
                if (load_acc) begin
                    acc        <= ACC_W'(pw) << (ACC_W - 16);
                    period_cnt <= 16'd0;
                end else if (state == ST_BURST) begin
                    acc <= acc_sum[ACC_W-1:0];
                    if (wrap) period_cnt <= period_cnt + 16'd1;
                end
                if (state == ST_BURST && state_nx == ST_GAP)
                    gap_cnt <= (gap == 16'd0) ? 16'd0 : gap - 16'd1;
                else if (state == ST_GAP && gap_cnt != 16'd0)
                    gap_cnt <= gap_cnt - 16'd1;
            end
        end

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                smp_cnt <= 16'd0;
                flag_q  <= 1'b0;
            end else if (!en || (ch_wr && reg_sel == 3'd6)) begin
                smp_cnt <= 16'd0;
                flag_q  <= 1'b0;
            end else if (smp_cnt == sdiv) begin
                smp_cnt <= 16'd0;
                flag_q  <= 1'b1;
            end else begin
                smp_cnt <= smp_cnt + 16'd1;
                flag_q  <= 1'b0;
            end
        end

        assign dds_data[c*OUT_W +: OUT_W] = dds_q;
        assign burst_active[c]            = (state == ST_BURST);
        assign burst_done[c]              = done_q;
        assign sample_flag[c]             = flag_q;
    end

endmodule

// File: tb/tb_dds_burst_gen.sv
// Scoreboard bench for dds_burst_gen: stimulus queues expected burst records,
// a negedge monitor pops one per completed burst and compares.
module tb_dds_burst_gen;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wrdata = 16'h0000;
    logic [1:0]  ext_trig = 2'b01;
    logic [23:0] dds_data;
    logic [1:0]  burst_active, burst_done, sample_flag;

    dds_burst_gen #(.NCH(2), .ACC_W(32), .OUT_W(12), .BASE_ADDR(8'h10)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
        .ext_trig(ext_trig), .dds_data(dds_data), .burst_active(burst_active),
        .burst_done(burst_done), .sample_flag(sample_flag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int len;
        int done;
        int sum;
        int gap;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    bit   prev_act[2];
    int   cur_len[2], cur_sum[2], cur_gap[2], idle_cnt[2];
    logic [11:0] mon_v;
    rec_t mon_e;
    bit   mon_have;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (mon_on) begin
            for (int c = 0; c < 2; c++) begin
                mon_v = dds_data[c*12 +: 12];
                if (burst_active[c]) begin
                    if (!prev_act[c]) begin
                        cur_gap[c] = idle_cnt[c];
                        cur_len[c] = 0;
                        cur_sum[c] = 0;
                    end
                    cur_len[c]++;
                    cur_sum[c] += int'(mon_v);
                    idle_cnt[c] = 0;
                    if (burst_done[c]) check("done_in_burst", burst_done[c], 0);
                end else if (prev_act[c]) begin
                    idle_cnt[c] = 1;
                    mon_have = 1'b0;
                    if (c == 0 && q0.size() > 0) begin
                        mon_e = q0.pop_front();
                        mon_have = 1'b1;
                    end else if (c == 1 && q1.size() > 0) begin
                        mon_e = q1.pop_front();
                        mon_have = 1'b1;
                    end
                    check("burst_expected", mon_have, 1);
                    if (mon_have) begin
                        check("burst_len", cur_len[c], mon_e.len);
                        check("burst_done", burst_done[c], mon_e.done);
                        if (mon_e.sum >= 0) check("burst_sum", cur_sum[c], mon_e.sum);
                        if (mon_e.gap >= 0) check("burst_gap", cur_gap[c], mon_e.gap);
                    end
                    check("mid_after_burst", mon_v, 12'h800);
                end else begin
                    idle_cnt[c]++;
                    if (burst_done[c]) check("stray_done", burst_done[c], 0);
                end
                prev_act[c] = burst_active[c];
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(posedge Clk); #1;
        m_wr = 1'b1; m_addr = a; m_wrdata = d;
        @(posedge Clk); #1;
        m_wr = 1'b0;
    endtask

    task automatic count_flags(input int cycles, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            n0 += int'(sample_flag[0]);
            n1 += int'(sample_flag[1]);
        end
    endtask

    int f0, f1;

    initial begin
        // ext_trig[0] held high through reset must never fire
        repeat (5) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_dds", dds_data, 24'h800800);
        check("rst_active", burst_active, 2'b00);
        check("rst_done", burst_done, 2'b00);
        check("rst_flag", sample_flag, 2'b00);
        mon_on = 1'b1;

        // defaults: SDIV=5 -> one flag per 6 clocks; FW/BURST_N/GAP defaults
        wr(8'h10, 16'h0001);
        wr(8'h18, 16'h0009);
        repeat (10) @(posedge Clk);
        count_flags(30, f0, f1);
        check("dflt_sdiv_ch0", f0, 5);
        check("dflt_sdiv_ch1", f1, 5);
        #1 ext_trig[0] = 1'b0;
        q1.push_back('{2500, 1, -1, -1});
        q1.push_back('{2500, 1, -1, 500});
        @(posedge Clk); #1 ext_trig[1] = 1'b1;
        @(posedge Clk); #1 ext_trig[1] = 1'b0;
        repeat (5600) @(posedge Clk);
        wr(8'h18, 16'h0000);
        repeat (10) @(posedge Clk);

        // ch0 square, FW=quarter turn, 3 periods
        wr(8'h11, 16'h0000);
        wr(8'h12, 16'h4000);
        wr(8'h14, 16'd3);
        q0.push_back('{12, 1, 22523, -1});
        wr(8'h17, 16'h0000);
        repeat (20) @(posedge Clk);

        // retrigger during burst is ignored
        q0.push_back('{12, 1, 22523, -1});
        wr(8'h17, 16'h0000);
        repeat (2) @(posedge Clk);
        wr(8'h17, 16'h0000);
        repeat (20) @(posedge Clk);

        // disable mid-burst: cut after 7 clocks, no done
        q0.push_back('{7, 0, 10238, -1});
        wr(8'h17, 16'h0000);
        repeat (4) @(posedge Clk);
        wr(8'h10, 16'h0000);
        repeat (5) @(posedge Clk);

        // saw then triangle, single period
        wr(8'h10, 16'h0003);
        wr(8'h14, 16'd1);
        q0.push_back('{4, 1, 5120, -1});
        wr(8'h17, 16'h0000);
        repeat (10) @(posedge Clk);
        wr(8'h10, 16'h0005);
        q0.push_back('{4, 1, 8190, -1});
        wr(8'h17, 16'h0000);
        repeat (10) @(posedge Clk);

        // BURST_N=0 blocks triggers
        wr(8'h14, 16'd0);
        wr(8'h17, 16'h0000);
        repeat (5) @(negedge Clk);
        check("burstn0_idle", burst_active[0], 1'b0);

        // ch1 continuous: 4-clock bursts with 10-clock gaps
        wr(8'h19, 16'h0000);
        wr(8'h1A, 16'h8000);
        wr(8'h1C, 16'd2);
        wr(8'h1D, 16'd10);
        wr(8'h18, 16'h0009);
        q1.push_back('{4, 1, 6143, -1});
        q1.push_back('{4, 1, 6143, 10});
        q1.push_back('{4, 1, 6143, 10});
        @(posedge Clk); #1 ext_trig[1] = 1'b1;
        @(posedge Clk); #1 ext_trig[1] = 1'b0;
        repeat (33) @(posedge Clk);
        wr(8'h18, 16'h0000);
        repeat (20) @(posedge Clk);

        // sample dividers per channel
        wr(8'h16, 16'd0);
        wr(8'h10, 16'h0001);
        wr(8'h1E, 16'd4);
        wr(8'h18, 16'h0001);
        repeat (5) @(posedge Clk);
        count_flags(20, f0, f1);
        check("sdiv0_ch0", f0, 20);
        check("sdiv4_ch1", f1, 4);

        // out-of-range writes must not alias onto any channel
        wr(8'h10, 16'h0000);
        wr(8'h18, 16'h0000);
        wr(8'h20, 16'h0001);
        wr(8'h2E, 16'd0);
        wr(8'h0F, 16'h0001);
        wr(8'h18, 16'h0001);
        repeat (5) @(posedge Clk);
        count_flags(20, f0, f1);
        check("oor_ch0_off", f0, 0);
        check("oor_ch1_sdiv", f1, 4);
        repeat (5) @(posedge Clk);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
